// File: rtl/spi_host_win_arb_pkg.sv
// Shared types and helpers for the SPI host data-window arbiter.
//   spi_reg_req_t : regbus request (valid, write, addr, wdata, wstrb)
//   spi_reg_rsp_t : regbus response (ready, error, rdata)
//   arb_state_e   : arbiter ownership state
//   rr_pick()     : masked round-robin pick over up to MaxReq requesters
package spi_host_win_arb_pkg;

    localparam int MaxReq  = 8;
    localparam int MaxIdxW = 3;
    localparam int AddrW   = 32;
    localparam int DataW   = 32;

    typedef struct packed {
        logic               valid;
        logic               write;
        logic [AddrW-1:0]   addr;
        logic [DataW-1:0]   wdata;
        logic [DataW/8-1:0] wstrb;
    } spi_reg_req_t;

    typedef struct packed {
        logic             ready;
        logic             error;
        logic [DataW-1:0] rdata;
    } spi_reg_rsp_t;

    typedef enum logic {
        ArbIdle,
        ArbOwned
    } arb_state_e;

    typedef struct packed {
        logic               vld;
        logic [MaxIdxW-1:0] idx;
    } rr_pick_t;

    // Lowest requester at or above ptr; if none, lowest requester overall.
    // Unused upper bits of req_vec must be zero, which makes wrapping at
    // MaxReq equivalent to wrapping at the real requester count.
    function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0]  req_vec,
                                         input logic [MaxIdxW-1:0] ptr);
        logic [MaxReq-1:0] masked;
        rr_pick_t          res;
        masked = req_vec & ~((MaxReq'(1) << ptr) - MaxReq'(1));
        res    = '0;
        for (int i = MaxReq - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                res.vld = 1'b1;
                res.idx = MaxIdxW'(i);
            end
        end
        for (int i = MaxReq - 1; i >= 0; i--) begin
            if (masked[i]) begin
                res.idx = MaxIdxW'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_host_win_rr_pick.sv
// Combinational round-robin pick.
//   req_vec : per-requester request bits
//   ptr     : first index allowed to win (search wraps)
//   idx     : winning requester index
//   vld     : at least one requester is asking
module spi_host_win_rr_pick
    import spi_host_win_arb_pkg::*;
#(
    parameter int NumReq = 2
) (
    input  logic [NumReq-1:0]         req_vec,
    input  logic [$clog2(NumReq)-1:0] ptr,
    output logic [$clog2(NumReq)-1:0] idx,
    output logic                      vld
);

    localparam int IdxW = $clog2(NumReq);

    logic [MaxReq-1:0]  req_pad;
    logic [MaxIdxW-1:0] ptr_pad;
    rr_pick_t           pick;

    always_comb begin
        req_pad               = '0;
        req_pad[NumReq-1:0]   = req_vec;
        ptr_pad               = MaxIdxW'(ptr);
        pick                  = rr_pick(req_pad, ptr_pad);
        // The range check can never reject a real pick (padding is zero);
        // it keeps the whole returned index in use for narrow NumReq.
        vld                   = pick.vld & ({1'b0, pick.idx} < (MaxIdxW+1)'(NumReq));
        idx                   = IdxW'(pick.idx);
    end

endmodule

// File: rtl/spi_host_win_arb.sv
// Shares the SPI host TX/RX data-FIFO windows between NumReq regbus
// requesters. One owner holds both windows for a tenure that ends after
// BurstLen beats or IdleCycles consecutive cycles without a valid.
//   clk_i, rst_ni             : clock, synchronous active-low reset
//   req_tx_win_i/o            : per-requester TX window request / response
//   req_rx_win_i/o            : per-requester RX window request / response
//   tx_win_o/i, rx_win_o/i    : single request / response to window adapter
//   owner_valid_o, owner_o    : current owner (owner_o is 0 when none)
//
// state    | meaning
// ArbIdle  | no owner; round-robin pick registered for next cycle
// ArbOwned | owner_q's requests pass through, responses return to owner only
module spi_host_win_arb
    import spi_host_win_arb_pkg::*;
#(
    parameter int  NumReq     = 2,
    parameter int  BurstLen   = 16,
    parameter int  IdleCycles = 4,
    parameter type reg_req_t  = spi_reg_req_t,
    parameter type reg_rsp_t  = spi_reg_rsp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  reg_req_t                  req_tx_win_i [NumReq],
    output reg_rsp_t                  req_tx_win_o [NumReq],
    input  reg_req_t                  req_rx_win_i [NumReq],
    output reg_rsp_t                  req_rx_win_o [NumReq],
    output reg_req_t                  tx_win_o,
    input  reg_rsp_t                  tx_win_i,
    output reg_req_t                  rx_win_o,
    input  reg_rsp_t                  rx_win_i,
    output logic                      owner_valid_o,
    output logic [$clog2(NumReq)-1:0] owner_o
);

    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(BurstLen + 2);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic [7:0]      idle_cnt_q, idle_cnt_d;

    logic [NumReq-1:0] req_vec;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_vld;

    logic              owned;
    logic              tx_beat;
    logic              rx_beat;
    logic [1:0]        beats;
    logic [CntW-1:0]   beat_sum;
    logic [7:0]        idle_inc;
    logic              owner_active;
    logic [IdxW-1:0]   owner_next;

    always_comb begin
        req_vec = '0;
        for (int r = 0; r < NumReq; r++) begin
            req_vec[r] = req_tx_win_i[r].valid | req_rx_win_i[r].valid;
        end
    end

    spi_host_win_rr_pick #(
        .NumReq (NumReq)
    ) u_rr_pick (
        .req_vec (req_vec),
        .ptr     (rr_ptr_q),
        .idx     (pick_idx),
        .vld     (pick_vld)
    );

    assign owned = (state_q == ArbOwned);

    // Request/response muxing: pass-through for the owner, zeros elsewhere.
    always_comb begin
        tx_win_o = '0;
        rx_win_o = '0;
        for (int r = 0; r < NumReq; r++) begin
            req_tx_win_o[r] = '0;
            req_rx_win_o[r] = '0;
        end
        if (owned) begin
            tx_win_o              = req_tx_win_i[owner_q];
            rx_win_o              = req_rx_win_i[owner_q];
            req_tx_win_o[owner_q] = tx_win_i;
            req_rx_win_o[owner_q] = rx_win_i;
        end
    end

    assign tx_beat      = owned & tx_win_o.valid & tx_win_i.ready;
    assign rx_beat      = owned & rx_win_o.valid & rx_win_i.ready;
    assign beats        = {1'b0, tx_beat} + {1'b0, rx_beat};
    // Never wraps: beat_cnt_q stays below BurstLen, so the sum is at most BurstLen+1.
    assign beat_sum     = beat_cnt_q + CntW'(beats);
    assign idle_inc     = idle_cnt_q + 8'd1;
    assign owner_active = tx_win_o.valid | rx_win_o.valid;
    assign owner_next   = (owner_q == IdxW'(NumReq - 1)) ? '0 : owner_q + IdxW'(1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            ArbIdle: begin
                if (pick_vld) begin
                    state_d    = ArbOwned;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            ArbOwned: begin
                beat_cnt_d = beat_sum;
                idle_cnt_d = owner_active ? 8'd0 : idle_inc;
                // The handshake of this cycle still completes; release only
                // changes who owns the windows from the next cycle on.
                if ((beat_sum >= CntW'(BurstLen)) ||
                    (!owner_active && (idle_inc >= 8'(IdleCycles)))) begin
                    state_d    = ArbIdle;
                    owner_d    = '0;
                    rr_ptr_d   = owner_next;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ArbIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign owner_valid_o = owned;
    assign owner_o       = owner_q;

endmodule

// File: tb/tb_spi_host_win_arb.sv
// Directed bench for spi_host_win_arb (NumReq=2, BurstLen=16, IdleCycles=4).
module tb_spi_host_win_arb;
    import spi_host_win_arb_pkg::*;

    logic         clk;
    logic         rst_n;
    spi_reg_req_t req_tx [2];
    spi_reg_rsp_t rsp_tx [2];
    spi_reg_req_t req_rx [2];
    spi_reg_rsp_t rsp_rx [2];
    spi_reg_req_t tx_win;
    spi_reg_rsp_t tx_rsp;
    spi_reg_req_t rx_win;
    spi_reg_rsp_t rx_rsp;
    logic         owner_valid;
    logic [0:0]   owner;

    int n_tests = 0;
    int n_fail  = 0;

    spi_host_win_arb #(
        .NumReq     (2),
        .BurstLen   (16),
        .IdleCycles (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_tx_win_i  (req_tx),
        .req_tx_win_o  (rsp_tx),
        .req_rx_win_i  (req_rx),
        .req_rx_win_o  (rsp_rx),
        .tx_win_o      (tx_win),
        .tx_win_i      (tx_rsp),
        .rx_win_o      (rx_win),
        .rx_win_i      (rx_rsp),
        .owner_valid_o (owner_valid),
        .owner_o       (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_reqs();
        for (int r = 0; r < 2; r++) begin
            req_tx[r] = '0;
            req_rx[r] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        tx_rsp = '0;
        rx_rsp = '0;
        tx_rsp.ready = 1'b1;
        rx_rsp.ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int own;
        rst_n = 1'b0;
        clear_reqs();
        tx_rsp = '0;
        rx_rsp = '0;
        tx_rsp.ready = 1'b1;
        rx_rsp.ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            req_tx[r].valid = 1'b1;
            req_rx[r].valid = 1'b1;
        end

        // Reset held 3 cycles with everyone requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            check_eq("rst_owner_valid", owner_valid, 0);
            check_eq("rst_owner", owner, 0);
            check_eq("rst_tx_valid", tx_win.valid, 0);
            check_eq("rst_rx_valid", rx_win.valid, 0);
            check_eq("rst_ready0", rsp_tx[0].ready, 0);
        end

        // Single requester, 20 TX writes: 16 beats, gap, 4 beats, idle release
        do_reset();
        req_tx[0].valid = 1'b1;
        req_tx[0].write = 1'b1;
        req_tx[0].wdata = 32'h100;
        settle();
        check_eq("t2_idle_owner_valid", owner_valid, 0);
        check_eq("t2_idle_ready", rsp_tx[0].ready, 0);
        for (int k = 0; k < 16; k++) begin
            tick();
            req_tx[0].wdata = 32'h100 + k;
            settle();
            check_eq("t2_owned", owner_valid, 1);
            check_eq("t2_tx_valid", tx_win.valid, 1);
            check_eq("t2_wdata", tx_win.wdata, 32'h100 + k);
            check_eq("t2_ready", rsp_tx[0].ready, 1);
        end
        tick();
        req_tx[0].wdata = 32'h110;
        settle();
        check_eq("t2_gap_owner_valid", owner_valid, 0);
        check_eq("t2_gap_tx_valid", tx_win.valid, 0);
        check_eq("t2_gap_ready", rsp_tx[0].ready, 0);
        for (int k = 16; k < 20; k++) begin
            tick();
            req_tx[0].wdata = 32'h100 + k;
            settle();
            check_eq("t2_regrant", owner_valid, 1);
            check_eq("t2_regrant_wdata", tx_win.wdata, 32'h100 + k);
        end
        tick();
        req_tx[0].valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            settle();
            check_eq("t2_idle_hold", owner_valid, 1);
        end
        tick();
        settle();
        check_eq("t2_idle_release", owner_valid, 0);

        // Two requesters from cycle 0: owner 0, then 1, then 0
        do_reset();
        req_tx[0].valid = 1'b1;
        req_tx[0].wdata = 32'hAAAA_0000;
        req_tx[1].valid = 1'b1;
        req_tx[1].wdata = 32'hBBBB_0000;
        tx_rsp.rdata    = 32'h5A5A;
        settle();
        check_eq("t3_idle", owner_valid, 0);
        for (int t = 0; t < 3; t++) begin
            own = (t == 1) ? 1 : 0;
            for (int b = 0; b < 16; b++) begin
                tick();
                settle();
                check_eq("t3_owner_valid", owner_valid, 1);
                check_eq("t3_owner", owner, own);
                check_eq("t3_wdata", tx_win.wdata, (own == 1) ? 32'hBBBB_0000 : 32'hAAAA_0000);
                check_eq("t3_owner_rdata", rsp_tx[own].rdata, 32'h5A5A);
                check_eq("t3_other_ready", rsp_tx[1-own].ready, 0);
                check_eq("t3_other_rdata", rsp_tx[1-own].rdata, 0);
            end
            if (t < 2) begin
                tick();
                settle();
                check_eq("t3_gap", owner_valid, 0);
            end
        end

        // Owner 1 stops after 3 beats; idle release after 4 cycles, then req0
        do_reset();
        req_tx[1].valid = 1'b1;
        req_tx[1].wdata = 32'hC;
        settle();
        check_eq("t4_idle", owner_valid, 0);
        for (int b = 0; b < 3; b++) begin
            tick();
            settle();
            check_eq("t4_owner1", owner, 1);
            check_eq("t4_owner1_valid", owner_valid, 1);
        end
        tick();
        req_tx[1].valid = 1'b0;
        req_tx[0].valid = 1'b1;
        req_tx[0].wdata = 32'hD;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            settle();
            check_eq("t4_hold_valid", owner_valid, 1);
            check_eq("t4_hold_owner", owner, 1);
            check_eq("t4_stall_ready0", rsp_tx[0].ready, 0);
            check_eq("t4_no_tx", tx_win.valid, 0);
        end
        tick();
        settle();
        check_eq("t4_release", owner_valid, 0);
        tick();
        settle();
        check_eq("t4_req0_valid", owner_valid, 1);
        check_eq("t4_req0_owner", owner, 0);
        check_eq("t4_req0_wdata", tx_win.wdata, 32'hD);

        // TX+RX beats in the same cycle at beat_cnt=15
        do_reset();
        req_tx[0].valid = 1'b1;
        req_tx[0].wdata = 32'h500;
        settle();
        for (int b = 0; b < 15; b++) begin
            tick();
            settle();
            check_eq("t5_owned", owner_valid, 1);
        end
        tick();
        req_rx[0].valid = 1'b1;
        rx_rsp.rdata    = 32'h77;
        settle();
        check_eq("t5_both_tx_ready", rsp_tx[0].ready, 1);
        check_eq("t5_both_rx_ready", rsp_rx[0].ready, 1);
        check_eq("t5_rx_valid", rx_win.valid, 1);
        check_eq("t5_rx_rdata", rsp_rx[0].rdata, 32'h77);
        check_eq("t5_still_owned", owner_valid, 1);
        tick();
        req_rx[0].valid = 1'b0;
        settle();
        check_eq("t5_release", owner_valid, 0);
        for (int b = 0; b < 16; b++) begin
            tick();
            settle();
            check_eq("t5_full_tenure", owner_valid, 1);
        end
        tick();
        settle();
        check_eq("t5_second_release", owner_valid, 0);

        // Downstream error to owner only; stalled ready holds ownership
        do_reset();
        tx_rsp.error    = 1'b1;
        rx_rsp.error    = 1'b1;
        req_tx[0].valid = 1'b1;
        req_tx[0].write = 1'b1;
        req_rx[1].valid = 1'b1;
        settle();
        tick();
        settle();
        check_eq("t6_owner", owner, 0);
        check_eq("t6_err_owner_tx", rsp_tx[0].error, 1);
        check_eq("t6_err_owner_rx", rsp_rx[0].error, 1);
        check_eq("t6_err_other_tx", rsp_tx[1].error, 0);
        check_eq("t6_err_other_rx", rsp_rx[1].error, 0);
        tick();
        settle();
        check_eq("t6_owner_kept", owner, 0);
        check_eq("t6_owner_valid_kept", owner_valid, 1);
        tx_rsp.error = 1'b0;
        rx_rsp.error = 1'b0;
        tx_rsp.ready = 1'b0;
        rx_rsp.ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            settle();
        end
        check_eq("t6_stall_owner_valid", owner_valid, 1);
        check_eq("t6_stall_owner", owner, 0);
        check_eq("t6_stall_tx_valid", tx_win.valid, 1);

        // Reset mid-tenure
        rst_n = 1'b0;
        tick();
        settle();
        check_eq("t7_rst_owner_valid", owner_valid, 0);
        check_eq("t7_rst_tx_valid", tx_win.valid, 0);
        check_eq("t7_rst_rx_valid", rx_win.valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
